output_queue: RTL and testbench

OUTPUT_QUEUE -- requirements
Module: output_queue

---
 rtl/output_queue.sv | 120 ++++++++++++
 tb/tb_output_queue.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/output_queue.sv
// rtl/output_queue.sv - token output queue with indexed, registered, fixed-latency read port
module output_queue #(
    parameter int INTEGER_PART_WIDTH    = 8,
    parameter int FRACTIONAL_PART_WIDTH = 8,
    parameter int OUTPUT_QUEUE_SIZE     = 64,
    localparam int NW = INTEGER_PART_WIDTH + FRACTIONAL_PART_WIDTH,
    localparam int EW = NW + 1,
    localparam int LW = $clog2(OUTPUT_QUEUE_SIZE + 1),
    localparam int IW = $clog2(OUTPUT_QUEUE_SIZE)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    input  logic          push,
    input  logic [EW-1:0] push_data,
    output logic          full,
    output logic          overflow,
    output logic [LW-1:0] output_queue_length,
    input  logic [IW-1:0] output_queue_index,
    input  logic          output_queue_get,
    output logic [EW-1:0] output_queue_data_out,
    output logic          output_queue_ready
);

    typedef enum logic [1:0] {
        IDLE,
        READ_ADDR,
        READ_DATA
    } state_t;

    state_t        state;
    state_t        state_d;
    logic [EW-1:0] mem [OUTPUT_QUEUE_SIZE];
    logic [EW-1:0] rd_q;
    logic [IW-1:0] rd_idx;
    logic          rd_oor;
    logic [LW-1:0] length;
    logic          do_write;
    logic          latch_req;
    logic          ready_d;
    logic [EW-1:0] data_out_d;

    assign full                = (length == LW'(OUTPUT_QUEUE_SIZE));
    assign output_queue_length = length;
    assign do_write            = rst_n && push && !clear && !full;

    // Storage has no reset: contents past length are never returned to a reader.
    always_ff @(posedge clk) begin
        if (do_write) begin
            mem[IW'(length)] <= push_data;
        end
        if (state == READ_ADDR) begin
            rd_q <= mem[rd_idx];
        end
    end

    // The range test uses the length seen when get was sampled, not at READ_DATA.
    always_ff @(posedge clk) begin
        if (latch_req) begin
            rd_idx <= output_queue_index;
            rd_oor <= (LW'(output_queue_index) >= length);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            length   <= '0;
            overflow <= 1'b0;
        end else if (clear) begin
            length   <= '0;
            overflow <= 1'b0;
        end else if (push) begin
            if (full) begin
                overflow <= 1'b1;
            end else begin
                length <= length + LW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state                 <= IDLE;
            output_queue_ready    <= 1'b0;
            output_queue_data_out <= '0;
        end else begin
            state                 <= state_d;
            output_queue_ready    <= ready_d;
            output_queue_data_out <= data_out_d;
        end
    end

    always_comb begin
        state_d    = state;
        latch_req  = 1'b0;
        ready_d    = output_queue_ready;
        data_out_d = output_queue_data_out;
        case (state)
            IDLE: begin
                if (output_queue_get) begin
                    latch_req = 1'b1;
                    ready_d   = 1'b0;
                    state_d   = READ_ADDR;
                end
            end
            READ_ADDR: begin
                state_d = READ_DATA;
            end
            READ_DATA: begin
                data_out_d = rd_oor ? '0 : rd_q;
                ready_d    = 1'b1;
                state_d    = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_output_queue.sv
// tb/tb_output_queue.sv - scoreboard bench for output_queue
module tb_output_queue;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clear;
    logic        push;
    logic [16:0] push_data;
    logic        full;
    logic        overflow;
    logic [6:0]  len;
    logic [5:0]  idx;
    logic        get;
    logic [16:0] dout;
    logic        rdy;

    logic [16:0] exp_q[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    logic        prev_rdy = 1'b0;

    output_queue dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .clear                (clear),
        .push                 (push),
        .push_data            (push_data),
        .full                 (full),
        .overflow             (overflow),
        .output_queue_length  (len),
        .output_queue_index   (idx),
        .output_queue_get     (get),
        .output_queue_data_out(dout),
        .output_queue_ready   (rdy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Read data is judged only when ready rises, so a stale ready never matches an entry.
    always @(negedge clk) begin
        if (rdy === 1'b1 && prev_rdy !== 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_ready", 32'd1, 32'd0);
            end else begin
                check("read_data", 32'(dout), 32'(exp_q.pop_front()));
            end
        end
        prev_rdy = rdy;
    end

    task automatic push_one(input logic [16:0] d);
        push      = 1'b1;
        push_data = d;
        tick();
        push = 1'b0;
    endtask

    task automatic do_get(input logic [5:0] i, input logic [16:0] e);
        exp_q.push_back(e);
        get = 1'b1;
        idx = i;
        tick();
        get = 1'b0;
        check("ready_low", 32'(rdy), 32'd0);
        tick();
        check("ready_still_low", 32'(rdy), 32'd0);
        tick();
        check("ready_rise", 32'(rdy), 32'd1);
    endtask

    task automatic wait_ready(input int bound);
        int n = 0;
        while (rdy !== 1'b1 && n < bound) begin
            tick();
            n++;
        end
        check("ready_timeout", 32'(rdy), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [16:0] rpn [3];
        rst_n = 1'b0; clear = 1'b0; push = 1'b0; push_data = '0; idx = '0; get = 1'b0;
        tick(); tick();
        check("rst_ready", 32'(rdy), 32'd0);
        check("rst_length", 32'(len), 32'd0);
        check("rst_data", 32'(dout), 32'd0);
        check("rst_full", 32'(full), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        rst_n = 1'b1;
        tick();

        push_one(17'h00300);
        push_one(17'h10006);
        push_one(17'h10000);
        check("len3", 32'(len), 32'd3);
        do_get(6'd1, 17'h10006);
        check("len3_after_get", 32'(len), 32'd3);

        clear = 1'b1; tick(); clear = 1'b0;
        for (int i = 0; i < 64; i++) push_one(17'(i * 3 + 1));
        check("full_at_64", 32'(full), 32'd1);
        check("len_64", 32'(len), 32'd64);
        check("no_overflow_yet", 32'(overflow), 32'd0);
        push_one(17'h0FFFF);
        check("len_after_drop", 32'(len), 32'd64);
        check("overflow_set", 32'(overflow), 32'd1);
        do_get(6'd0, 17'd1);
        do_get(6'd63, 17'd190);
        // clear lands while the read is in flight; stored data must still come back
        exp_q.push_back(17'd7);
        get = 1'b1; idx = 6'd2; tick();
        get = 1'b0; clear = 1'b1; tick();
        clear = 1'b0; tick();
        check("inflight_ready", 32'(rdy), 32'd1);
        check("clear_len", 32'(len), 32'd0);
        check("clear_full", 32'(full), 32'd0);
        check("clear_overflow", 32'(overflow), 32'd0);

        for (int i = 0; i < 5; i++) push_one(17'h00100 + 17'(i));
        check("len5", 32'(len), 32'd5);
        push = 1'b1; clear = 1'b1; push_data = 17'h0ABCD; tick();
        push = 1'b0; clear = 1'b0;
        check("push_clear_len", 32'(len), 32'd0);
        check("push_clear_ovf", 32'(overflow), 32'd0);

        push_one(17'h00A00);
        push_one(17'h10003);
        push_one(17'h00500);
        // index 7 holds old data from the 64-entry fill, so a zero proves the range test
        exp_q.push_back(17'h00000);
        get = 1'b1; idx = 6'd7; tick();
        check("oor_ready_low", 32'(rdy), 32'd0);
        idx = 6'd0; tick();
        get = 1'b0; tick();
        check("oor_ready", 32'(rdy), 32'd1);
        tick();
        check("second_get_ignored", 32'(rdy), 32'd1);
        check("len3_b", 32'(len), 32'd3);
        do_get(6'd1, 17'h10003);

        get = 1'b1; idx = 6'd2; tick();
        get = 1'b0; rst_n = 1'b0; tick();
        check("abort_ready", 32'(rdy), 32'd0);
        check("abort_len", 32'(len), 32'd0);
        check("abort_data", 32'(dout), 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        check("no_late_ready", 32'(rdy), 32'd0);

        rpn[0] = 17'h00300; rpn[1] = 17'h00200; rpn[2] = 17'h10000;
        for (int i = 0; i < 3; i++) push_one(rpn[i]);
        check("rpn_len", 32'(len), 32'd3);
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(rpn[i]);
            get = 1'b1; idx = 6'(i); tick();
            get = 1'b0;
            check("no_stale_ready", 32'(rdy), 32'd0);
            wait_ready(8);
        end
        tick();
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
